// File: rtl/expr_pipe_eval_if.sv
// rtl/expr_pipe_eval_if.sv - operand/result handshake bundle for expr_pipe_eval
interface expr_pipe_eval_if #(
    parameter int AW = 6,
    parameter int BW = 6,
    parameter int YW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] y;
    logic          flag;
    logic [15:0]   ops_done;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, flag, ops_done
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, flag, ops_done
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// rtl/expr_pipe_eval.sv - pipelined width/sign-aware expression evaluator with elastic handshake
module expr_pipe_eval #(
    parameter int AW       = 6,
    parameter int BW       = 6,
    parameter int A_SIGNED = 1,
    parameter int B_SIGNED = 1,
    parameter int YW       = 8,
    parameter int STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    expr_pipe_eval_if.slave  bus
);
    // Mixed signedness collapses to the unsigned domain, as in a Verilog expression.
    localparam bit SDOM = (A_SIGNED != 0) && (B_SIGNED != 0);

    logic [63:0]       ea64, eb64, sum64, dif64, prd64;
    logic [YW-1:0]     ea, eb, cy;
    logic              cf, r, sh_big;

    logic [STAGES-1:0] v, en, fr;
    logic [YW-1:0]     yr [STAGES];
    logic [15:0]       done_cnt;

    function automatic logic fits(input logic [63:0] x);
        logic [63:0] hi;
        if (SDOM) begin
            hi = $signed(x) >>> (YW - 1);
            return (hi == '0) || (hi == '1);
        end
        return (x >> YW) == '0;
    endfunction

    always_comb begin
        if (SDOM) begin
            ea64 = 64'($signed(bus.a));
            eb64 = 64'($signed(bus.b));
        end else begin
            ea64 = 64'(bus.a);
            eb64 = 64'(bus.b);
        end
    end

    // 64-bit intermediates hold the exact result of any 16x16 operation.
    assign sum64  = ea64 + eb64;
    assign dif64  = ea64 - eb64;
    assign prd64  = ea64 * eb64;
    assign ea     = ea64[YW-1:0];
    assign eb     = eb64[YW-1:0];
    assign sh_big = 32'(bus.b) >= 32'(YW);

    always_comb begin
        cy = '0;
        cf = 1'b0;
        r  = 1'b0;
        case (bus.op)
            3'd0: begin cy = sum64[YW-1:0]; cf = !fits(sum64); end
            3'd1: begin cy = dif64[YW-1:0]; cf = !fits(dif64); end
            3'd2: begin cy = prd64[YW-1:0]; cf = !fits(prd64); end
            3'd3: begin
                if (!sh_big) cy = ea << bus.b;
            end
            3'd4: begin
                if (sh_big) begin
                    if (SDOM) cy = {YW{ea[YW-1]}};
                end else if (SDOM) begin
                    cy = $signed(ea) >>> bus.b;
                end else begin
                    cy = ea >> bus.b;
                end
            end
            3'd5: begin
                if (SDOM) r = $signed(ea) < $signed(eb);
                else      r = ea < eb;
                cy = {{(YW-1){1'b0}}, r};
                cf = r;
            end
            3'd6: begin
                r  = ea != eb;
                cy = {{(YW-1){1'b0}}, r};
                cf = r;
            end
            default: begin
                r  = ~^(ea ^ eb);
                cy = {{(YW-1){1'b0}}, r};
                cf = r;
            end
        endcase
    end

    // Stage k may load when out_ready or any stage at or after k is empty.
    always_comb begin
        en = '0;
        for (int k = 0; k < STAGES; k++) begin
            en[k] = bus.out_ready ||
                    !(&(v | ((STAGES'(1) << k) - STAGES'(1))));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v        <= '0;
            fr       <= '0;
            done_cnt <= '0;
            for (int k = 0; k < STAGES; k++) yr[k] <= '0;
        end else begin
            if (en[0]) begin
                v[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    yr[0] <= cy;
                    fr[0] <= cf;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        yr[k] <= yr[k-1];
                        fr[k] <= fr[k-1];
                    end
                end
            end
            if (v[STAGES-1] && bus.out_ready) done_cnt <= done_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.y         = yr[STAGES-1];
    assign bus.flag      = fr[STAGES-1];
    assign bus.ops_done  = done_cnt;
endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb/tb_expr_pipe_eval.sv - self-checking bench for expr_pipe_eval
module tb_expr_pipe_eval;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    expr_pipe_eval_if #(.AW(6), .BW(6), .YW(8)) bus ();
    expr_pipe_eval_if #(.AW(6), .BW(6), .YW(8)) bus2 ();

    expr_pipe_eval dut (.clk(clk), .reset(reset), .bus(bus));
    expr_pipe_eval #(.B_SIGNED(0)) dut_mix (.clk(clk), .reset(reset), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] q [$];
    int exp_done;
    int idx, emitted, last_c;
    bit consec;
    logic [5:0] bp_a [4];
    logic [5:0] bp_b [4];
    logic [2:0] bp_op [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic on the operand values, then truncate.
    function automatic logic [8:0] model(input logic [5:0] a, input logic [5:0] b,
                                         input logic [2:0] op, input bit sdom);
        longint va, vb, rr;
        int sh, ones;
        logic [7:0] yy;
        bit f;
        if (sdom) begin
            va = longint'($signed(a));
            vb = longint'($signed(b));
        end else begin
            va = longint'(a);
            vb = longint'(b);
        end
        sh = int'(b);
        f  = 1'b0;
        rr = 0;
        case (op)
            3'd0: rr = va + vb;
            3'd1: rr = va - vb;
            3'd2: rr = va * vb;
            3'd3: rr = (sh >= 8) ? 0 : va * (longint'(1) << sh);
            3'd4: begin
                if (sh >= 8) rr = (va < 0) ? -1 : 0;
                else         rr = va >>> sh;
            end
            3'd5: rr = (va < vb) ? 1 : 0;
            3'd6: rr = (va != vb) ? 1 : 0;
            default: begin
                ones = 0;
                for (int i = 0; i < 8; i++) if ((((va ^ vb) >> i) & 1) != 0) ones++;
                rr = (ones % 2 == 0) ? 1 : 0;
            end
        endcase
        yy = rr[7:0];
        if (op <= 3'd2) f = sdom ? (rr < -128 || rr > 127) : (rr < 0 || rr > 255);
        else if (op >= 3'd5) f = rr[0];
        return {f, yy};
    endfunction

    task automatic dir(input string tag, input logic [5:0] ta, input logic [5:0] tb_,
                       input logic [2:0] top, input logic [8:0] exp);
        bus.a = ta; bus.b = tb_; bus.op = top;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1 chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
        chk(tag, 32'({bus.flag, bus.y}), 32'(exp));
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.op = 0; bus.out_ready = 1;
        bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.op = 0; bus2.out_ready = 1;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_flag", 32'(bus.flag), 32'd0);
        chk("rst_ops_done", 32'(bus.ops_done), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        dir("add",     6'h3D, 6'd5,  3'd0, 9'h002);
        dir("mul_ovf", 6'd31, 6'd31, 3'd2, 9'h1C1);
        dir("mul_neg", 6'd3,  6'h3E, 3'd2, 9'h0FA);
        dir("ashr3",   6'h20, 6'd3,  3'd4, 9'h0FC);
        dir("ashr9",   6'h20, 6'd9,  3'd4, 9'h0FF);
        dir("shl9",    6'h20, 6'd9,  3'd3, 9'h000);

        // Same lt stimulus into the signed and the mixed-sign instances.
        bus.a = 6'h3F; bus.b = 6'd1; bus.op = 3'd5; bus.in_valid = 1;
        bus2.a = 6'h3F; bus2.b = 6'd1; bus2.op = 3'd5; bus2.in_valid = 1;
        tick();
        bus.in_valid = 0; bus2.in_valid = 0;
        tick();
        chk("lt_signed", 32'({bus.flag, bus.y}), 32'h101);
        chk("lt_mixed_v", 32'(bus2.out_valid), 32'd1);
        chk("lt_mixed", 32'({bus2.flag, bus2.y}), 32'h000);
        tick();
        chk("dir_ops_done", 32'(bus.ops_done), 32'd7);

        exp_done = 7;
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = 6'($urandom);
            bus.b         = 6'($urandom);
            bus.op        = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
                else begin
                    chk("rnd_out", 32'({bus.flag, bus.y}), 32'(q[0]));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        exp_done++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.op, 1'b1));
            chk("rnd_capacity", 32'(q.size() <= 2), 32'd1);
            tick();
        end
        bus.in_valid = 0; bus.out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.out_valid && q.size() != 0) begin
                chk("drain_out", 32'({bus.flag, bus.y}), 32'(q[0]));
                void'(q.pop_front());
                exp_done++;
            end
            tick();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("rnd_ops_done", 32'(bus.ops_done), 32'(exp_done & 16'hFFFF));

        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 6'($urandom); bp_b[i] = 6'($urandom); bp_op[i] = 3'($urandom);
        end
        idx = 0;
        bus.out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 4);
            if (idx < 4) begin bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.op = bp_op[idx]; end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.op, 1'b1));
                idx++;
            end
            tick();
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_held_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1;
        emitted = 0; last_c = 0; consec = 1'b1;
        for (int c = 0; c < 20 && emitted < 4; c++) begin
            bus.in_valid = (idx < 4);
            if (idx < 4) begin bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.op = bp_op[idx]; end
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) chk("bp_spurious", 32'd1, 32'd0);
                else begin
                    chk("bp_out", 32'({bus.flag, bus.y}), 32'(q[0]));
                    void'(q.pop_front());
                end
                if (emitted > 0 && c != last_c + 1) consec = 1'b0;
                last_c = c;
                emitted++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.op, 1'b1));
                idx++;
            end
            tick();
        end
        bus.in_valid = 0;
        chk("bp_emitted", 32'(emitted), 32'd4);
        chk("bp_consecutive", 32'(consec), 32'd1);
        chk("bp_ops_done", 32'(bus.ops_done), 32'd4);

        // Two transactions parked, then reset asserted between clock edges.
        bus.out_ready = 0;
        bus.a = 6'd1; bus.b = 6'd2; bus.op = 3'd0; bus.in_valid = 1;
        tick();
        tick();
        bus.in_valid = 0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ops_done", 32'(bus.ops_done), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        bus.out_ready = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
        end
        dir("post_rst_add", 6'd10, 6'd20, 3'd0, 9'h01E);
        chk("post_rst_ops_done", 32'(bus.ops_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/expr_pipe_eval.md
Name: expr_pipe_eval

Overview:
- Parametrised, pipelined successor to the combinational mixed-signedness expression blocks in the regression set.
- Evaluates one selectable operator per transaction on two operands whose width and signedness are set by parameters.
- Extension and signedness follow Verilog context rules.
- Valid/ready elastic handshake on input and output; serves as a sequential regression target for width/sign semantics under backpressure.

Parameters:
- AW, 6, width of operand a (2..16)
- BW, 6, width of operand b (2..16)
- A_SIGNED, 1, 1 = a is signed
- B_SIGNED, 1, 1 = b is signed
- YW, 8, result width (>= max(AW,BW), <= 32)
- STAGES, 2, pipeline depth in registers (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block accepts the transaction this cycle
- a  in  AW  operand a
- b  in  BW  operand b
- op  in  3  operator select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- y  out  YW  result
- flag  out  1  overflow flag or compare result
- ops_done  out  16  count of completed output handshakes, wraps

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid=0, y=0, flag=0, ops_done=0. in_ready=1 after release.
- Domain: signed only if A_SIGNED && B_SIGNED; otherwise both operands are zero-extended to YW (mixed → unsigned, as Verilog).
- In the signed domain, operands are sign-extended to YW.
- op encoding (ea/eb = extended operands):
  - 0 add: y = ea+eb
  - 1 sub: y = ea-eb
  - 2 mul: y = low YW bits of ea*eb
  - 3 shl: y = ea << sh
  - 4 ashr: y = ea >>> sh; sign fill only in signed domain
  - 5 lt: ea < eb, evaluated in the domain
  - 6 ne: a !== b, on extended values
  - 7 xnor-reduce: ~^(ea ^ eb)
- Shift amount sh = b's low bits treated unsigned.
  - sh >= YW: shl gives 0.
  - sh >= YW: ashr gives all sign bits in signed domain, else 0.
- Ops 5-7: y = {YW-1 zeros, r}, flag = r.
- Ops 0-2: flag = 1 when the exact result does not fit YW in the domain.
  - Signed overflow or unsigned carry/borrow for add/sub.
  - Full-product check for mul.
- Ops 3-4: flag = 0.
- Pipeline:
  - Compute occurs in stage 0; remaining stages are registers.
  - Latency from accept to out_valid is STAGES cycles when unstalled.
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
  - Bubbles collapse.
  - in_ready = !v0 || advance0, combinational from out_ready through the chain.
  - Capacity is STAGES transactions.
- Output stability: while out_valid && !out_ready, y and flag hold stable.
- Simultaneous accept in the same cycle as output drain is allowed: full throughput of 1/cycle.
- Ordering is strictly FIFO: no drop, no duplication.
- ops_done increments on each out_valid && out_ready and wraps 16'hFFFF → 0.
- Inputs are ignored when in_valid=0 or in_ready=0.
- Reset mid-operation discards all in-flight results; no stale output appears after release.

Test Plan:
(Defaults unless stated: AW=BW=6, signed, YW=8, STAGES=2.)
- Add: a=6'h3D (-3), b=5, op=0 -> y=8'h02, flag=0; out_valid asserted exactly 2 cycles after accept.
- Mixed sign (B_SIGNED=0): a=6'h3F, b=1, op=5 -> y=0 (63<1 false). Same stimulus with defaults -> y=1, flag=1.
- Mul overflow: a=31, b=31, op=2 -> y=8'hC1, flag=1. a=3, b=-2, op=2 -> y=8'hFA, flag=0.
- Shift: a=6'h20 (-32), b=3, op=4 -> y=8'hFC. b=9 -> y=8'hFF. op=3 with b=9 -> y=0.
- Backpressure: out_ready=0 for 6 cycles while offering 4 back-to-back ops.
  - in_ready falls after 2 accepts.
  - On release, all 4 results emerge in order, 1/cycle.
  - ops_done=4.
- Reset: assert reset with 2 transactions in flight -> out_valid=0 and ops_done=0 immediately, without waiting for a clock edge. After release, no output until a new accept.
